// File: rtl/fetch_align_if.sv
// Fetch/align bus bundle: redirect and hold controls from the back end, the
// instruction-RAM port, and the fetch-to-decode pipeline register outputs.
interface fetch_align_if;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        hold;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] fetch_pc;
    logic [31:0] rv32_instr_todec;
    logic        fe2de_rv16;
    logic        cross_bd_ff;

    // Fetch unit side: drives the RAM address and the decode-facing outputs.
    modport master (
        input  redirect,
        input  redirect_pc,
        input  hold,
        input  imem_rdata,
        output imem_addr,
        output fetch_pc,
        output rv32_instr_todec,
        output fe2de_rv16,
        output cross_bd_ff
    );

    // Environment side: back-end controls plus the instruction RAM.
    modport slave (
        output redirect,
        output redirect_pc,
        output hold,
        output imem_rdata,
        input  imem_addr,
        input  fetch_pc,
        input  rv32_instr_todec,
        input  fe2de_rv16,
        input  cross_bd_ff
    );
endinterface

// File: rtl/fetch_align.sv
// Front-end fetch/align unit. Generates the PC and the instruction-RAM word
// address, and turns the 32-bit word stream into one RV32 or RV16 instruction
// per cycle. The upper halfword of a fetched word is kept in a residue register
// so that compressed pairs and 32-bit instructions straddling a word boundary
// are presented without re-reading memory.
module fetch_align #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic           clk,
    input logic           cpurst_n,
    fetch_align_if.master bus
);

    typedef enum logic {
        BOOT,
        RUN
    } fsm_e;

    // Which alignment situation the current cycle falls into while running.
    typedef enum logic [2:0] {
        CASE_A,   // aligned pc, RV16 in D[15:0]
        CASE_B,   // aligned pc, RV32 in D
        CASE_C,   // odd halfword, residue holds an RV16
        CASE_D,   // odd halfword, residue holds the low half of an RV32
        CASE_E,   // odd halfword, no residue, RV16 in D[31:16]
        CASE_F    // odd halfword, no residue, RV32 starts in D[31:16]: bubble
    } align_e;

    localparam logic [31:1] RESET_PC_H = RESET_PC[31:1];

    // Registered state
    fsm_e        fsm_q;
    logic [31:1] pc_q;
    logic [31:2] addr_q;
    logic [15:0] res_q;
    logic        res_v_q;

    // Next-state values
    fsm_e        fsm_d;
    logic [31:1] pc_d;
    logic [31:2] addr_d;
    logic [15:0] res_d;
    logic        res_v_d;

    logic [31:0] rdata;
    align_e      sel;

    assign rdata = bus.imem_rdata;

    // Classify the alignment case from the registered pc/residue and RAM data.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path through the block can infer a latch.
        sel = CASE_A;
        if (!pc_q[1]) begin
            sel = (rdata[1:0] != 2'b11) ? CASE_A : CASE_B;
        end else if (res_v_q) begin
            sel = (res_q[1:0] != 2'b11) ? CASE_C : CASE_D;
        end else begin
            sel = (rdata[17:16] != 2'b11) ? CASE_E : CASE_F;
        end
    end

    // Decode-facing outputs. The instruction depends only on state and RAM
    // data; redirect can only force the bubble flag, never the instruction.
    always_comb begin
        bus.rv32_instr_todec = 32'h0000_0000;
        bus.fe2de_rv16       = 1'b0;
        bus.cross_bd_ff      = 1'b1;
        if (fsm_q == RUN) begin
            unique case (sel)
                CASE_A: begin
                    bus.rv32_instr_todec = {16'h0000, rdata[15:0]};
                    bus.fe2de_rv16       = 1'b1;
                    bus.cross_bd_ff      = 1'b0;
                end
                CASE_B: begin
                    bus.rv32_instr_todec = rdata;
                    bus.cross_bd_ff      = 1'b0;
                end
                CASE_C: begin
                    bus.rv32_instr_todec = {16'h0000, res_q};
                    bus.fe2de_rv16       = 1'b1;
                    bus.cross_bd_ff      = 1'b0;
                end
                CASE_D: begin
                    bus.rv32_instr_todec = {rdata[15:0], res_q};
                    bus.cross_bd_ff      = 1'b0;
                end
                CASE_E: begin
                    bus.rv32_instr_todec = {16'h0000, rdata[31:16]};
                    bus.fe2de_rv16       = 1'b1;
                    bus.cross_bd_ff      = 1'b0;
                end
                CASE_F: begin
                    bus.cross_bd_ff      = 1'b1;
                end
                default: begin
                    bus.cross_bd_ff      = 1'b1;
                end
            endcase
        end
        if (bus.redirect) begin
            bus.cross_bd_ff = 1'b1;
        end
    end

    // Next pc / RAM address / residue, in priority redirect > boot > hold > run.
    always_comb begin
        fsm_d   = fsm_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        res_d   = res_q;
        res_v_d = res_v_q;
        if (bus.redirect) begin
            pc_d    = bus.redirect_pc[31:1];
            addr_d  = bus.redirect_pc[31:2];
            res_v_d = 1'b0;
            fsm_d   = RUN;
        end else if (fsm_q == BOOT) begin
            addr_d = pc_q[31:2];
            fsm_d  = RUN;
        end else if (bus.hold) begin
            // Re-read the same word so the same instruction is presented again.
            addr_d = addr_q;
        end else begin
            unique case (sel)
                CASE_A: begin
                    pc_d    = pc_q + 31'd1;
                    res_d   = rdata[31:16];
                    res_v_d = 1'b1;
                    addr_d  = addr_q + 30'd1;
                end
                CASE_B: begin
                    pc_d    = pc_q + 31'd2;
                    res_v_d = 1'b0;
                    addr_d  = addr_q + 30'd1;
                end
                CASE_C: begin
                    // The word on rdata already holds the new pc; read it again.
                    pc_d    = pc_q + 31'd1;
                    res_v_d = 1'b0;
                    addr_d  = addr_q;
                end
                CASE_D: begin
                    pc_d    = pc_q + 31'd2;
                    res_d   = rdata[31:16];
                    res_v_d = 1'b1;
                    addr_d  = addr_q + 30'd1;
                end
                CASE_E: begin
                    pc_d    = pc_q + 31'd1;
                    addr_d  = addr_q + 30'd1;
                end
                CASE_F: begin
                    res_d   = rdata[31:16];
                    res_v_d = 1'b1;
                    addr_d  = addr_q + 30'd1;
                end
                default: begin
                    addr_d  = addr_q;
                end
            endcase
        end
    end

    assign bus.imem_addr = {addr_d, 2'b00};
    assign bus.fetch_pc  = {pc_q, 1'b0};

    // Control state register with asynchronous reset back to BOOT.
    always_ff @(posedge clk or negedge cpurst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!cpurst_n) begin
            fsm_q   <= BOOT;
            pc_q    <= RESET_PC_H;
            addr_q  <= RESET_PC[31:2];
            res_v_q <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            res_v_q <= res_v_d;
        end
    end

    // Residue halfword data register.
    always_ff @(posedge clk) begin
        // NOTE: res_q is pure data qualified by res_v_q, so it is deliberately left out of reset.
        res_q <= res_d;
    end

endmodule

// File: tb/tb_fetch_align.sv
// Testbench for fetch_align: a directed table of cycle-by-cycle vectors covering
// boot, boundary crossing, odd redirects, hold and mid-stream reset, followed by
// randomized traffic checked against a halfword-stream reference model.
module tb_fetch_align;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic clk = 1'b0;
    logic cpurst_n = 1'b0;

    fetch_align_if bus ();

    fetch_align #(.RESET_PC(RST_PC)) dut (
        .clk      (clk),
        .cpurst_n (cpurst_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    // Synchronous instruction RAM, one-cycle read latency, 4 KiB window.
    logic [31:0] mem [0:1023];
    always @(posedge clk) bus.imem_rdata <= mem[bus.imem_addr[11:2]];

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst_n;
        logic        redirect;
        logic [31:0] redirect_pc;
        logic        hold;
        logic        exp_cross;
        logic [31:0] exp_addr;
        logic [31:0] exp_pc;
        logic        chk_instr;
        logic [31:0] exp_instr;
        logic        exp_rv16;
    } vec_t;

    function automatic vec_t mk(logic r, logic rd, logic [31:0] rpc, logic h, logic c,
                                logic [31:0] a, logic [31:0] p, logic ci,
                                logic [31:0] ins, logic r16);
        vec_t v;
        v.rst_n = r; v.redirect = rd; v.redirect_pc = rpc; v.hold = h;
        v.exp_cross = c; v.exp_addr = a; v.exp_pc = p; v.chk_instr = ci;
        v.exp_instr = ins; v.exp_rv16 = r16;
        return v;
    endfunction

    // Reference: the instruction at a PC, read directly from the memory image.
    function automatic logic [15:0] half(input logic [31:0] a);
        logic [31:0] w;
        w = mem[a[11:2]];
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    vec_t vecs[$];

    initial begin
        logic [31:0] model_pc;
        logic [15:0] h0;
        logic [31:0] e_instr;
        logic        e_rv16;
        int          bub;
        logic        prev_hv;
        logic [31:0] p_pc, p_instr;
        logic        p_rv16, p_cross;
        logic [31:0] p_addr;
        logic [31:0] rpc;

        bus.redirect = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.hold = 1'b0;

        for (int i = 0; i < 1024; i++) mem[i] = 32'h0001_0001;
        mem[32'h100 >> 2] = 32'h00A0_0093;
        mem[32'h104 >> 2] = 32'h4501_4505;
        mem[32'h108 >> 2] = 32'h0001_0001;
        mem[32'h200 >> 2] = 32'h0093_4505;
        mem[32'h204 >> 2] = 32'h1234_00A0;
        mem[32'h300 >> 2] = 32'h0093_0001;
        mem[32'h304 >> 2] = 32'h0001_00A0;
        mem[32'h308 >> 2] = 32'h0001_4505;

        //              rst rd rpc          hd cr addr       pc         ci instr        rv16
        vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'h100, 32'h100, 1, 32'h0,        0)); // in reset
        vecs.push_back(mk(1, 0, 32'h0,        0, 1, 32'h100, 32'h100, 0, 32'h0,        0)); // boot bubble
        vecs.push_back(mk(1, 0, 32'h0,        0, 0, 32'h104, 32'h100, 1, 32'h00A00093, 0)); // B
        vecs.push_back(mk(1, 0, 32'h0,        0, 0, 32'h108, 32'h104, 1, 32'h4505,     1)); // A
        vecs.push_back(mk(1, 0, 32'h0,        0, 0, 32'h108, 32'h106, 1, 32'h4501,     1)); // C re-read
        vecs.push_back(mk(1, 0, 32'h0,        0, 0, 32'h10C, 32'h108, 1, 32'h0001,     1)); // A
        vecs.push_back(mk(1, 1, 32'h200,      1, 1, 32'h200, 32'h10A, 0, 32'h0,        0)); // redirect+hold
        vecs.push_back(mk(1, 0, 32'h0,        0, 0, 32'h204, 32'h200, 1, 32'h4505,     1)); // A
        vecs.push_back(mk(1, 0, 32'h0,        0, 0, 32'h208, 32'h202, 1, 32'h00A00093, 0)); // D crossing
        vecs.push_back(mk(1, 0, 32'h0,        0, 0, 32'h208, 32'h206, 1, 32'h1234,     1)); // C residue
        vecs.push_back(mk(1, 1, 32'h303,      0, 1, 32'h300, 32'h208, 0, 32'h0,        0)); // odd redirect
        vecs.push_back(mk(1, 0, 32'h0,        0, 1, 32'h304, 32'h302, 0, 32'h0,        0)); // F bubble
        vecs.push_back(mk(1, 0, 32'h0,        1, 0, 32'h304, 32'h302, 1, 32'h00A00093, 0)); // hold 1
        vecs.push_back(mk(1, 0, 32'h0,        1, 0, 32'h304, 32'h302, 1, 32'h00A00093, 0)); // hold 2
        vecs.push_back(mk(1, 0, 32'h0,        1, 0, 32'h304, 32'h302, 1, 32'h00A00093, 0)); // hold 3
        vecs.push_back(mk(1, 0, 32'h0,        0, 0, 32'h308, 32'h302, 1, 32'h00A00093, 0)); // D resumes
        vecs.push_back(mk(1, 0, 32'h0,        0, 0, 32'h308, 32'h306, 1, 32'h0001,     1)); // C
        vecs.push_back(mk(1, 0, 32'h0,        0, 0, 32'h30C, 32'h308, 1, 32'h4505,     1)); // A, res_v=1
        vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'h100, 32'h100, 1, 32'h0,        0)); // async reset
        vecs.push_back(mk(1, 0, 32'h0,        0, 1, 32'h100, 32'h100, 0, 32'h0,        0)); // boot
        vecs.push_back(mk(1, 0, 32'h0,        0, 0, 32'h104, 32'h100, 1, 32'h00A00093, 0)); // B from RESET_PC

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            cpurst_n = vecs[i].rst_n;
            bus.redirect = vecs[i].redirect;
            bus.redirect_pc = vecs[i].redirect_pc;
            bus.hold = vecs[i].hold;
            #1;
            check($sformatf("v%0d_cross", i), {31'h0, bus.cross_bd_ff}, {31'h0, vecs[i].exp_cross});
            check($sformatf("v%0d_imem_addr", i), bus.imem_addr, vecs[i].exp_addr);
            check($sformatf("v%0d_fetch_pc", i), bus.fetch_pc, vecs[i].exp_pc);
            if (vecs[i].chk_instr) begin
                check($sformatf("v%0d_instr", i), bus.rv32_instr_todec, vecs[i].exp_instr);
                check($sformatf("v%0d_rv16", i), {31'h0, bus.fe2de_rv16}, {31'h0, vecs[i].exp_rv16});
            end
        end

        // Randomized phase: random memory image, random redirects and holds.
        for (int i = 0; i < 1024; i++) begin
            logic [15:0] lo, hi;
            lo = 16'($urandom);
            hi = 16'($urandom);
            if ($urandom_range(1, 0) == 1) lo[1:0] = 2'b11; else if (lo[1:0] == 2'b11) lo[1:0] = 2'b01;
            if ($urandom_range(1, 0) == 1) hi[1:0] = 2'b11; else if (hi[1:0] == 2'b11) hi[1:0] = 2'b10;
            mem[i] = {hi, lo};
        end

        @(negedge clk);
        cpurst_n = 1'b0;
        bus.redirect = 1'b0;
        bus.hold = 1'b0;
        @(negedge clk);
        cpurst_n = 1'b1;
        model_pc = RST_PC;
        bub = 0;
        prev_hv = 1'b0;
        p_pc = 0; p_instr = 0; p_rv16 = 0; p_cross = 0; p_addr = 0;

        for (int c = 0; c < 3000; c++) begin
            if (c != 0) @(negedge clk);
            bus.redirect = ($urandom_range(15, 0) == 0);
            if ($urandom_range(7, 0) == 0) rpc = 32'hFFFF_FFF8 + 32'($urandom_range(7, 0));
            else rpc = $urandom;
            bus.redirect_pc = rpc;
            bus.hold = ($urandom_range(3, 0) == 0);
            #1;

            check("imem_addr_align", {30'h0, bus.imem_addr[1:0]}, 32'h0);

            if (prev_hv && !bus.redirect) begin
                check("hold_pc", bus.fetch_pc, p_pc);
                check("hold_instr", bus.rv32_instr_todec, p_instr);
                check("hold_rv16", {31'h0, bus.fe2de_rv16}, {31'h0, p_rv16});
                check("hold_cross", {31'h0, bus.cross_bd_ff}, {31'h0, p_cross});
                if (bus.hold) check("hold_addr", bus.imem_addr, p_addr);
            end

            if (bus.redirect) begin
                check("redir_addr", bus.imem_addr, {rpc[31:2], 2'b00});
                check("redir_bubble", {31'h0, bus.cross_bd_ff}, 32'h1);
                model_pc = {rpc[31:1], 1'b0};
                bub = 0;
            end else if (!bus.cross_bd_ff) begin
                bub = 0;
                if (!bus.hold) begin
                    h0 = half(model_pc);
                    if (h0[1:0] == 2'b11) begin
                        e_instr = {half(model_pc + 32'd2), h0};
                        e_rv16 = 1'b0;
                    end else begin
                        e_instr = {16'h0, h0};
                        e_rv16 = 1'b1;
                    end
                    check("rand_pc", bus.fetch_pc, model_pc);
                    check("rand_instr", bus.rv32_instr_todec, e_instr);
                    check("rand_rv16", {31'h0, bus.fe2de_rv16}, {31'h0, e_rv16});
                    model_pc = model_pc + (e_rv16 ? 32'd2 : 32'd4);
                end
            end else if (!bus.hold) begin
                bub++;
                check("bubble_run_len", {31'h0, (bub > 1)}, 32'h0);
            end

            prev_hv = bus.hold && !bus.redirect && !bus.cross_bd_ff;
            p_pc = bus.fetch_pc;
            p_instr = bus.rv32_instr_todec;
            p_rv16 = bus.fe2de_rv16;
            p_cross = bus.cross_bd_ff;
            p_addr = bus.imem_addr;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
